// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: forwarding-select codes and the
// MUL/DIV occupancy state type.
package cpu_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Pipeline-state inputs and stage-control outputs of the hazard unit.
// The core side uses the master modport, the hazard unit the slave modport.
interface pipe_hazard_unit_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    import cpu_pkg::*;

    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [RA_W-1:0]  ex_rs;
    logic [RA_W-1:0]  ex_rt;
    logic [RA_W-1:0]  ex_dst;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_is_muldiv;
    logic [RA_W-1:0]  mem_dst;
    logic             mem_reg_write;
    logic [RA_W-1:0]  wb_dst;
    logic             wb_reg_write;
    logic             branch_taken;
    logic             perf_clr;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             ifid_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             muldiv_busy;
    logic             muldiv_done;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    md_state_t        md_state;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_dst,
               ex_reg_write, ex_mem_read, ex_is_muldiv, mem_dst, mem_reg_write,
               wb_dst, wb_reg_write, branch_taken, perf_clr,
        input  pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble,
               ifid_flush, fwd_a, fwd_b, muldiv_busy, muldiv_done,
               stall_cnt, flush_cnt, md_state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_dst,
               ex_reg_write, ex_mem_read, ex_is_muldiv, mem_dst, mem_reg_write,
               wb_dst, wb_reg_write, branch_taken, perf_clr,
        output pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble,
               ifid_flush, fwd_a, fwd_b, muldiv_busy, muldiv_done,
               stall_cnt, flush_cnt, md_state
    );

endinterface

// File: rtl/pipe_fwd_sel.sv
// Forwarding select for one EX operand; EX/MEM beats MEM/WB and r0 is
// never forwarded.
module pipe_fwd_sel
    import cpu_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            en,
    input  logic [RA_W-1:0] src,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] mem_dst,
    input  logic            wb_reg_write,
    input  logic [RA_W-1:0] wb_dst,
    output logic [1:0]      sel
);

    always_comb begin
        sel = FWD_RF;
        if (en) begin
            if (mem_reg_write && (mem_dst != '0) && (mem_dst == src)) begin
                sel = FWD_MEM;
            end else if (wb_reg_write && (wb_dst != '0) && (wb_dst == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and pipeline-control unit: stage enables, bubbles,
// flushes, MUL/DIV occupancy FSM and saturating stall/flush counters.
module pipe_hazard_unit
    import cpu_pkg::*;
#(
    parameter int RA_W   = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    pipe_hazard_unit_if.slave hz
);

    localparam int            CW      = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] MD_LOAD = (MD_LAT > 1) ? CW'(MD_LAT - 2) : '0;

    md_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic md_stall, md_done, load_use, branch_ok;
    logic pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble, ifid_flush;
    logic [1:0] fwd_a, fwd_b;

    // cnt holds the stall cycles still owed after the current one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_stall = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.ex_is_muldiv) begin
                    if (MD_LAT > 1) begin
                        md_stall = 1'b1;
                        cnt_d    = MD_LOAD;
                        state_d  = MD_BUSY;
                    end else begin
                        md_done = 1'b1;
                    end
                end
            end
            MD_BUSY: begin
                if (cnt_q != '0) begin
                    md_stall = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    md_done = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign load_use = hz.ex_mem_read && (hz.ex_dst != '0) &&
                      ((hz.id_uses_rs && (hz.id_rs == hz.ex_dst)) ||
                       (hz.id_uses_rt && (hz.id_rt == hz.ex_dst)));
    assign branch_ok = reset && hz.branch_taken && !md_stall;

    // Priority: MUL/DIV stall, then taken branch, then load-use.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        ifid_flush   = 1'b0;
        if (reset) begin
            if (md_stall) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
            end else if (hz.branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (branch_ok && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .en(reset), .src(hz.ex_rs),
        .mem_reg_write(hz.mem_reg_write), .mem_dst(hz.mem_dst),
        .wb_reg_write(hz.wb_reg_write), .wb_dst(hz.wb_dst), .sel(fwd_a)
    );

    pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .en(reset), .src(hz.ex_rt),
        .mem_reg_write(hz.mem_reg_write), .mem_dst(hz.mem_dst),
        .wb_reg_write(hz.wb_reg_write), .wb_dst(hz.wb_dst), .sel(fwd_b)
    );

    assign hz.pc_write     = pc_write;
    assign hz.ifid_write   = ifid_write;
    assign hz.idex_write   = idex_write;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.exmem_bubble = exmem_bubble;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.fwd_a        = fwd_a;
    assign hz.fwd_b        = fwd_b;
    assign hz.muldiv_busy  = reset && md_stall;
    assign hz.muldiv_done  = reset && md_done;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;
    assign hz.md_state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed steps then random traffic, checked
// against a cycle-level reference model for MD_LAT=4 and MD_LAT=1 instances.
module tb_pipe_hazard_unit;
    import cpu_pkg::*;

    localparam int RA_W  = 5;
    localparam int CNT_W = 4;
    localparam int W     = 12;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [W-1:0] exp_q[$];

    bit m_in_md[2];
    int m_age[2];
    int m_sc[2];
    int m_fc[2];
    bit m_stall[2];
    bit m_br[2];
    bit m_pcw[2];

    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.RA_W(RA_W), .CNT_W(CNT_W)) hz0 ();
    pipe_hazard_unit_if #(.RA_W(RA_W), .CNT_W(CNT_W)) hz1 ();

    pipe_hazard_unit #(.RA_W(RA_W), .MD_LAT(4), .CNT_W(CNT_W)) dut (
        .clock(clk), .reset(rst_n), .hz(hz0)
    );
    pipe_hazard_unit #(.RA_W(RA_W), .MD_LAT(1), .CNT_W(CNT_W)) dut1 (
        .clock(clk), .reset(rst_n), .hz(hz1)
    );

    assign hz1.id_rs         = hz0.id_rs;
    assign hz1.id_rt         = hz0.id_rt;
    assign hz1.id_uses_rs    = hz0.id_uses_rs;
    assign hz1.id_uses_rt    = hz0.id_uses_rt;
    assign hz1.ex_rs         = hz0.ex_rs;
    assign hz1.ex_rt         = hz0.ex_rt;
    assign hz1.ex_dst        = hz0.ex_dst;
    assign hz1.ex_reg_write  = hz0.ex_reg_write;
    assign hz1.ex_mem_read   = hz0.ex_mem_read;
    assign hz1.ex_is_muldiv  = hz0.ex_is_muldiv;
    assign hz1.mem_dst       = hz0.mem_dst;
    assign hz1.mem_reg_write = hz0.mem_reg_write;
    assign hz1.wb_dst        = hz0.wb_dst;
    assign hz1.wb_reg_write  = hz0.wb_reg_write;
    assign hz1.branch_taken  = hz0.branch_taken;
    assign hz1.perf_clr      = hz0.perf_clr;

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_fwd(input logic [RA_W-1:0] src);
        if (hz0.mem_reg_write && hz0.mem_dst != 0 && hz0.mem_dst == src) return 2'b10;
        if (hz0.wb_reg_write && hz0.wb_dst != 0 && hz0.wb_dst == src) return 2'b01;
        return 2'b00;
    endfunction

    // age = cycles the current MUL/DIV has already spent in EX.
    function automatic logic [W-1:0] ref_ctrl(input int lat, input bit in_md, input int age,
                                              output bit stall, output bit br_ok);
        bit done = 0, lu = 0;
        bit pc = 1, ifid = 1, idex = 1, idb = 0, exb = 0, fl = 0;
        logic [1:0] fa = 2'b00, fb = 2'b00;
        stall = 0;
        br_ok = 0;
        if (rst_n) begin
            fa = ref_fwd(hz0.ex_rs);
            fb = ref_fwd(hz0.ex_rt);
            if (!in_md) begin
                if (hz0.ex_is_muldiv) begin
                    if (lat > 1) stall = 1;
                    else done = 1;
                end
            end else if (age < lat - 1) stall = 1;
            else done = 1;
            lu = hz0.ex_mem_read && hz0.ex_dst != 0 &&
                 ((hz0.id_uses_rs && hz0.id_rs == hz0.ex_dst) ||
                  (hz0.id_uses_rt && hz0.id_rt == hz0.ex_dst));
            if (stall) begin
                pc = 0; ifid = 0; idex = 0; exb = 1;
            end else if (hz0.branch_taken) begin
                fl = 1; idb = 1; br_ok = 1;
            end else if (lu) begin
                pc = 0; ifid = 0; idb = 1;
            end
        end
        return {pc, ifid, idex, idb, exb, fl, fa, fb, stall, done};
    endfunction

    function automatic logic [W-1:0] obs0();
        return {hz0.pc_write, hz0.ifid_write, hz0.idex_write, hz0.idex_bubble,
                hz0.exmem_bubble, hz0.ifid_flush, hz0.fwd_a, hz0.fwd_b,
                hz0.muldiv_busy, hz0.muldiv_done};
    endfunction

    function automatic logic [W-1:0] obs1();
        return {hz1.pc_write, hz1.ifid_write, hz1.idex_write, hz1.idex_bubble,
                hz1.exmem_bubble, hz1.ifid_flush, hz1.fwd_a, hz1.fwd_b,
                hz1.muldiv_busy, hz1.muldiv_done};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    // One clock: check outputs mid-cycle, then advance the model past the edge.
    task automatic cyc();
        logic [W-1:0] obs[2];
        logic [W-1:0] exp_v;
        @(negedge clk);
        obs[0] = obs0();
        obs[1] = obs1();
        for (int i = 0; i < 2; i++)
            exp_q.push_back(ref_ctrl((i == 0) ? 4 : 1, m_in_md[i], m_age[i], m_stall[i], m_br[i]));
        for (int i = 0; i < 2; i++) begin
            exp_v    = exp_q.pop_front();
            m_pcw[i] = exp_v[W-1];
            check($sformatf("ctrl%0d", i), obs[i], exp_v);
        end
        check("stall_cnt0", W'(hz0.stall_cnt), W'(m_sc[0]));
        check("flush_cnt0", W'(hz0.flush_cnt), W'(m_fc[0]));
        check("stall_cnt1", W'(hz1.stall_cnt), W'(m_sc[1]));
        check("flush_cnt1", W'(hz1.flush_cnt), W'(m_fc[1]));
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_in_md[i] = 0; m_age[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            end else begin
                if (m_stall[i]) begin
                    if (!m_in_md[i]) begin
                        m_in_md[i] = 1; m_age[i] = 1;
                    end else m_age[i]++;
                end else if (m_in_md[i]) begin
                    m_in_md[i] = 0; m_age[i] = 0;
                end
                if (hz0.perf_clr) begin
                    m_sc[i] = 0; m_fc[i] = 0;
                end else begin
                    if (!m_pcw[i] && m_sc[i] < CMAX) m_sc[i]++;
                    if (m_br[i] && m_fc[i] < CMAX) m_fc[i]++;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_idle();
        rst_n = 1;
        hz0.id_rs = 0; hz0.id_rt = 0; hz0.id_uses_rs = 0; hz0.id_uses_rt = 0;
        hz0.ex_rs = 0; hz0.ex_rt = 0; hz0.ex_dst = 0;
        hz0.ex_reg_write = 0; hz0.ex_mem_read = 0; hz0.ex_is_muldiv = 0;
        hz0.mem_dst = 0; hz0.mem_reg_write = 0; hz0.wb_dst = 0; hz0.wb_reg_write = 0;
        hz0.branch_taken = 0; hz0.perf_clr = 0;
    endtask

    task automatic set_random();
        rst_n = ($urandom_range(0, 49) != 0);
        hz0.id_rs = RA_W'($urandom_range(0, 3)); hz0.id_rt = RA_W'($urandom_range(0, 3));
        hz0.id_uses_rs = 1'($urandom_range(0, 1)); hz0.id_uses_rt = 1'($urandom_range(0, 1));
        hz0.ex_rs = RA_W'($urandom_range(0, 3)); hz0.ex_rt = RA_W'($urandom_range(0, 3));
        hz0.ex_dst = RA_W'($urandom_range(0, 3));
        hz0.ex_reg_write = 1'($urandom_range(0, 1)); hz0.ex_mem_read = 1'($urandom_range(0, 1));
        hz0.ex_is_muldiv = ($urandom_range(0, 5) == 0);
        hz0.mem_dst = RA_W'($urandom_range(0, 3)); hz0.mem_reg_write = 1'($urandom_range(0, 1));
        hz0.wb_dst = RA_W'($urandom_range(0, 3)); hz0.wb_reg_write = 1'($urandom_range(0, 1));
        hz0.branch_taken = ($urandom_range(0, 5) == 0);
        hz0.perf_clr = ($urandom_range(0, 29) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        rst_n = 0;
        cyc(); cyc();
        set_idle();
        cyc();

        // Forwarding priority and r0 suppression
        hz0.mem_reg_write = 1; hz0.mem_dst = 3; hz0.wb_reg_write = 1; hz0.wb_dst = 3; hz0.ex_rs = 3;
        cyc();
        check("fwd_a_mem", W'(hz0.fwd_a), W'(2'b10));
        hz0.mem_dst = 0;
        cyc();
        check("fwd_a_wb", W'(hz0.fwd_a), W'(2'b01));
        set_idle();
        hz0.wb_dst = 0; hz0.wb_reg_write = 1; hz0.ex_rt = 0;
        cyc();
        check("fwd_b_r0", W'(hz0.fwd_b), W'(2'b00));

        // Load-use, with and without the source actually read
        set_idle();
        hz0.ex_mem_read = 1; hz0.ex_dst = 5; hz0.id_rs = 5; hz0.id_uses_rs = 1;
        cyc();
        check("lu_pc_write", W'(hz0.pc_write), W'(1'b0));
        check("lu_bubble", W'(hz0.idex_bubble), W'(1'b1));
        hz0.id_uses_rs = 0;
        cyc();
        check("lu_unused_pc", W'(hz0.pc_write), W'(1'b1));

        // Two back-to-back MUL/DIVs: 6 stall cycles
        set_idle();
        hz0.perf_clr = 1;
        cyc();
        hz0.perf_clr = 0; hz0.ex_is_muldiv = 1;
        repeat (8) cyc();
        hz0.ex_is_muldiv = 0;
        cyc();
        check("md_stall6", W'(hz0.stall_cnt), W'(6));

        // Branch overrides load-use
        hz0.ex_mem_read = 1; hz0.ex_dst = 5; hz0.id_rs = 5; hz0.id_uses_rs = 1; hz0.branch_taken = 1;
        cyc();
        check("br_flush", W'(hz0.ifid_flush), W'(1'b1));
        check("br_pc_write", W'(hz0.pc_write), W'(1'b1));
        check("br_flush_cnt", W'(hz0.flush_cnt), W'(1));

        // Branch during MD_BUSY is ignored
        set_idle();
        hz0.ex_is_muldiv = 1;
        cyc();
        hz0.ex_is_muldiv = 0; hz0.branch_taken = 1;
        cyc();
        check("md_br_flush", W'(hz0.ifid_flush), W'(1'b0));
        check("md_br_cnt", W'(hz0.flush_cnt), W'(1));
        set_idle();
        cyc(); cyc();

        // Reset in the middle of MD_BUSY
        hz0.ex_is_muldiv = 1;
        cyc();
        hz0.ex_is_muldiv = 0; rst_n = 0;
        cyc();
        rst_n = 1;
        cyc();
        check("rst_md_busy", W'(hz0.muldiv_busy), W'(1'b0));
        check("rst_stall_cnt", W'(hz0.stall_cnt), W'(0));
        check("rst_state", W'(hz0.md_state), W'(RUN));

        // Saturation, then clear
        hz0.ex_is_muldiv = 1;
        repeat (24) cyc();
        hz0.ex_is_muldiv = 0;
        cyc();
        check("sat_stall_cnt", W'(hz0.stall_cnt), W'(CMAX));
        hz0.perf_clr = 1;
        cyc();
        hz0.perf_clr = 0;
        cyc();
        check("clr_stall_cnt", W'(hz0.stall_cnt), W'(0));

        // Random traffic against the model
        repeat (400) begin
            set_random();
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
